// File: rtl/vga_bounce_gen.sv
// Bouncing-square pixel source feeding vga_ctrl; pixel is registered one clock after pix_x/pix_y.
// Optional macro BOUNCE_GRID_EN replaces the black background with a 64-pixel grid.
module vga_bounce_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX      = 32,
  parameter int STEP     = 2,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [11:0] pixel
);

  localparam logic [10:0] H_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_W    = 11'(V_ACTIVE);
  localparam logic [10:0] BOX_W  = 11'(BOX);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  INIT_X_V = 10'(INIT_X);
  localparam logic [9:0]  INIT_Y_V = 10'(INIT_Y);

  logic [9:0]  bx_r, by_r, prev_x_r, prev_y_r;
  logic        dir_x_r, dir_y_r;
  logic [2:0]  cidx_r;
  logic        tick_s, active_s, inside_s;
  logic [11:0] ax_s, ay_s;
  logic [11:0] bg_s, pix_nxt_s;

  // Palette in {B,G,R} nibble order.
  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 12'h00F;
      3'd1:    palette = 12'h0F0;
      3'd2:    palette = 12'hF00;
      3'd3:    palette = 12'h0FF;
      3'd4:    palette = 12'hF0F;
      3'd5:    palette = 12'hFF0;
      3'd6:    palette = 12'hFFF;
      3'd7:    palette = 12'h888;
      default: palette = 12'h000;
    endcase
  endfunction

  // Returns {bounce, new_dir, new_pos}; sums kept 11 bits wide to avoid overflow.
  function automatic logic [11:0] axis_next(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] limit);
    logic [10:0] pos_w;
    pos_w = {1'b0, pos};
    if (dir) begin
      if (pos_w + BOX_W + STEP_W > limit) axis_next = {1'b1, 1'b0, 10'(limit - BOX_W)};
      else                                axis_next = {1'b0, 1'b1, 10'(pos_w + STEP_W)};
    end else if (pos_w < STEP_W) begin
      axis_next = {1'b1, 1'b1, 10'd0};
    end else begin
      axis_next = {1'b0, 1'b0, 10'(pos_w - STEP_W)};
    end
  endfunction

  // Tick detection, next motion state and pixel selection.
  always_comb begin
    tick_s   = (pix_x == 10'(H_ACTIVE - 1)) && (pix_y == 10'(V_ACTIVE - 1)) &&
               ((pix_x != prev_x_r) || (pix_y != prev_y_r));
    ax_s     = axis_next(bx_r, dir_x_r, H_W);
    ay_s     = axis_next(by_r, dir_y_r, V_W);
    active_s = ({1'b0, pix_x} < H_W) && ({1'b0, pix_y} < V_W);
    inside_s = (pix_x >= bx_r) && ({1'b0, pix_x} < {1'b0, bx_r} + BOX_W) &&
               (pix_y >= by_r) && ({1'b0, pix_y} < {1'b0, by_r} + BOX_W);
`ifdef BOUNCE_GRID_EN
    if ((pix_x[5:0] == 6'd0) || (pix_y[5:0] == 6'd0)) bg_s = 12'h444;
    else                                              bg_s = 12'h000;
`else
    bg_s     = 12'h000;
`endif
    if (!active_s)     pix_nxt_s = 12'h000;
    else if (inside_s) pix_nxt_s = palette(cidx_r);
    else               pix_nxt_s = bg_s;
  end

  // Motion/colour state, previous-coordinate tracker and registered pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bx_r     <= INIT_X_V;
      by_r     <= INIT_Y_V;
      dir_x_r  <= 1'b1;
      dir_y_r  <= 1'b1;
      cidx_r   <= 3'd0;
      prev_x_r <= 10'd0;
      prev_y_r <= 10'd0;
      pixel    <= 12'h000;
    end else begin
      prev_x_r <= pix_x;
      prev_y_r <= pix_y;
      pixel    <= pix_nxt_s;
      if (tick_s && en) begin
        bx_r    <= ax_s[9:0];
        dir_x_r <= ax_s[10];
        by_r    <= ay_s[9:0];
        dir_y_r <= ay_s[10];
        // A double-axis bounce still advances the colour only once.
        if (ax_s[11] || ay_s[11]) cidx_r <= cidx_r + 3'd1;
      end
    end
  end

endmodule
